instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage sitting directly upstream of `instruction_executor`. It holds the architectural PC, reads the instruction memory, and presents `pc`/`instruction` to the executor for a fixed execution window. It then takes the executor's `npc` as the next fetch address. It also detects HALT, gates the executor with NOPs outside the execution window, and counts retired instructions.

## Interface
- `IMEM_ADDR_WIDTH`, 10: instruction memory address width; PC is truncated to this width for `imem_addr`.
- `WIDTH`, 32: PC, instruction and counter width.
- `RESET_PC`, 0: PC value loaded on reset.
- `EXEC_CYCLES`, 3: cycles each instruction is held at the executor; legal range 1..15.
- `clk`  in  1  sole clock, all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  freezes FSM, PC, counters while high.
- `imem_en`  out  1  read enable to instruction BRAM (registered-output, 1-cycle read latency).
- `imem_addr`  out  IMEM_ADDR_WIDTH  BRAM read address = `pc_reg[IMEM_ADDR_WIDTH-1:0]`.
- `imem_data`  in  WIDTH  BRAM read data, valid the cycle after `imem_en`.
- `npc`  in  WIDTH  next PC from executor.
- `pc`  out  WIDTH  PC of the instruction being presented.
- `instruction`  out  WIDTH  instruction to executor; 32'h0 (NOP) outside EXEC.
- `instr_valid`  out  1  high while a real instruction is presented.
- `halted`  out  1  sticky; high after HALT fetched.
- `retired`  out  WIDTH  count of instructions whose npc was accepted.

## Operation
- States: FETCH, LATCH, EXEC, HALT. Counter `exec_cnt` (4 bits).
- FETCH: `imem_en`=1, `imem_addr`=pc_reg; next state LATCH.
- LATCH: `imem_en`=0; capture `imem_data` into `ir`. If `imem_data[31:29]==3'b000` and `imem_data[28]==1` (HALT), go to HALT; else go to EXEC with `exec_cnt`=0.
- EXEC: `instruction`=`ir`, `instr_valid`=1, `exec_cnt` increments each cycle. On the cycle with `exec_cnt==EXEC_CYCLES-1`: set `pc_reg`<=`npc`, increment `retired`, go to FETCH.
- HALT: `halted`=1, `instr_valid`=0, `instruction`=0, `imem_en`=0. Only exits on `rst`.
- Outside EXEC, `instruction`=0 (NOP) and `instr_valid`=0, so the free-running executor performs no register or stack side effects.
- `pc` output = `pc_reg` in all states.
- Stall:
  - Holds state, `exec_cnt`, `pc_reg`, `ir` and `retired`.
  - Forces `imem_en`=0, `instruction`=0, `instr_valid`=0.
  - A stall in FETCH re-issues the read when released.
  - A stall in LATCH keeps BRAM output unchanged because enable is low, so the capture stays valid.
  - A stall in EXEC resumes counting from the frozen value.
- `stall` has no effect in HALT.
- Arithmetic: `retired` wraps at 2^WIDTH.
- `npc` is accepted unmodified. Addresses beyond the memory wrap via truncation of `imem_addr`; `pc` keeps the full value.
- Non-HALT opcode-000 encodings (NOP) execute normally.

## Timing
- Reset values: state=FETCH, `pc_reg`=RESET_PC, `ir`=0, `exec_cnt`=0, `retired`=0, `halted`=0, `instr_valid`=0, `instruction`=0. `imem_en`=1 in the first cycle after `rst` falls.
- `rst` asserted in any state, including mid-EXEC or HALT, takes effect at the next edge; an in-flight instruction is discarded and not retired.
- `rst` has priority over `stall`.
- Per instruction with no stall: 1 FETCH + 1 LATCH + EXEC_CYCLES cycles, i.e. 5 cycles at default.
- Next FETCH uses the `npc` sampled at the last EXEC edge.
- HALT: `halted` rises 2 cycles after its FETCH cycle; `retired` is not incremented for HALT.
- All outputs are driven from registered state. `imem_addr`, `imem_en`, `instruction` and `instr_valid` may be decoded combinationally from state, `stall` and `ir`.

## Test plan
- Reset, memory [0]=ADD, executor-model npc=pc+1, EXEC_CYCLES=3 -> `imem_en` pulses at cycles 0, 5, 10; pc = 0, 1, 2; `retired`=2 after cycle 10.
- Branch: npc driven to 0x2A at the end of the first EXEC -> next `imem_addr`=0x2A; `pc`=0x2A.
- HALT word 0x10000000 at address 3 -> `halted`=1 two cycles after fetch of 3; `retired`=3; `instr_valid` and `imem_en` stay 0 for 20 further cycles.
- Stall:
  - `stall` high for 4 cycles during the 2nd EXEC cycle -> `instruction`=0 during stall; instruction retires exactly 4 cycles late.
  - `stall` during FETCH -> read re-issued after release.
- Reset mid-EXEC and from HALT -> next cycle FETCH at RESET_PC; `retired`=0; `halted`=0.
- npc=0x400 with IMEM_ADDR_WIDTH=10 -> `imem_addr`=0x000, `pc`=0x400.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, imem read, timed presentation to the executor
module instruction_fetch_unit #(
    parameter int                  IMEM_ADDR_WIDTH = 10,
    parameter int                  WIDTH           = 32,
    parameter logic [WIDTH-1:0]    RESET_PC        = '0,
    parameter int                  EXEC_CYCLES     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    output logic                       imem_en,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0]           imem_data,
    input  logic [WIDTH-1:0]           npc,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           instruction,
    output logic                       instr_valid,
    output logic                       halted,
    output logic [WIDTH-1:0]           retired
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LATCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] ir;
    logic [3:0]       exec_cnt;
    logic [WIDTH-1:0] retired_cnt;
    logic             is_halt_word;
    logic             exec_last;

    // HALT is opcode 000 with bit 28 set; other opcode-000 words are ordinary NOPs
    assign is_halt_word = (imem_data[31:29] == 3'b000) && imem_data[28];
    assign exec_last    = (exec_cnt == EXEC_LAST);

    // State register; reset wins over stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; stall freezes every state except HALT, which only reset leaves
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: if (!stall) state_next = S_LATCH;
            S_LATCH: if (!stall) state_next = is_halt_word ? S_HALT : S_EXEC;
            S_EXEC:  if (!stall && exec_last) state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath: capture the read word, pace the execution window, retire and take npc
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            ir          <= '0;
            exec_cnt    <= '0;
            retired_cnt <= '0;
        end else if (!stall) begin
            case (state)
                S_LATCH: begin
                    ir       <= imem_data;
                    exec_cnt <= '0;
                end
                S_EXEC: begin
                    if (exec_last) begin
                        pc_reg      <= npc;
                        retired_cnt <= retired_cnt + 1'b1;
                    end else begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; outside an unstalled EXEC the executor sees a NOP
    always_comb begin
        imem_en     = (state == S_FETCH) && !stall;
        instr_valid = (state == S_EXEC) && !stall;
        instruction = instr_valid ? ir : '0;
        halted      = (state == S_HALT);
        imem_addr   = pc_reg[IMEM_ADDR_WIDTH-1:0];
        pc          = pc_reg;
        retired     = retired_cnt;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam int AW = 10;
    localparam int W  = 32;
    localparam int EC = 3;
    localparam int P  = EC + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [W-1:0]  imem_data = '0;
    logic [W-1:0]  npc = '0;
    logic [W-1:0]  pc;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic          halted;
    logic [W-1:0]  retired;

    logic [W-1:0]  mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    int unsigned   m_slots;
    logic [W-1:0]  m_pc;
    logic [W-1:0]  m_ret;
    bit            m_halt;

    instruction_fetch_unit #(
        .IMEM_ADDR_WIDTH(AW),
        .WIDTH(W),
        .RESET_PC('0),
        .EXEC_CYCLES(EC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .npc(npc),
        .pc(pc),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Registered-output BRAM with one cycle of read latency
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_halt_word(input logic [W-1:0] w);
        return (w[31:29] == 3'b000) && w[28];
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    // Model: each instruction occupies P unstalled cycles (fetch, latch, EC execute);
    // stalled cycles consume nothing; a HALT word seen at latch freezes everything.
    task automatic cycle(input bit r, input bit s, input logic [W-1:0] n);
        int          slot;
        bit          en_e;
        bit          v_e;
        logic [W-1:0] ins_e;
        @(negedge clk);
        rst = r;
        stall = s;
        npc = n;
        #1;
        if (r) begin
            m_slots = 0;
            m_pc = '0;
            m_ret = '0;
            m_halt = 1'b0;
            return;
        end
        slot = int'(m_slots % P);
        en_e = 1'b0;
        v_e = 1'b0;
        if (!m_halt && !s) begin
            en_e = (slot == 0);
            v_e = (slot >= 2);
        end
        ins_e = v_e ? mem[m_pc[AW-1:0]] : '0;
        check_eq("imem_en", 32'(imem_en), 32'(en_e));
        check_eq("instr_valid", 32'(instr_valid), 32'(v_e));
        check_eq("instruction", instruction, ins_e);
        check_eq("halted", 32'(halted), 32'(m_halt));
        check_eq("pc", pc, m_pc);
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
        check_eq("retired", retired, m_ret);
        if (!m_halt && !s) begin
            if (slot == 1 && is_halt_word(mem[m_pc[AW-1:0]])) begin
                m_halt = 1'b1;
            end else begin
                if (slot == P - 1) begin
                    m_pc = n;
                    m_ret = m_ret + 1;
                end
                m_slots++;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'($urandom % 2), $urandom);
        cycle(1'b1, 1'($urandom % 2), $urandom);
    endtask

    function automatic logic [W-1:0] pick_npc();
        case ($urandom % 4)
            0, 1:    return m_pc + 1;
            2:       return $urandom;
            default: return 32'($urandom % 2048);
        endcase
    endfunction

    initial begin
        m_slots = 0;
        m_pc = '0;
        m_ret = '0;
        m_halt = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h2000_0000 | 32'(i);
        mem[3] = 32'h1000_0000;

        // Sequential run into a HALT at address 3
        do_reset();
        repeat (40) cycle(1'b0, 1'b0, m_pc + 1);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_retired", retired, 32'd3);
        check_eq("halt_pc", pc, 32'd3);
        repeat (4) cycle(1'b0, 1'b1, m_pc + 1);

        // Reset out of HALT, then branch to 0x2A and to 0x400 (address wraps)
        mem[3] = 32'h2000_0003;
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 32'h2A);
        repeat (5) cycle(1'b0, 1'b0, 32'h400);
        cycle(1'b0, 1'b0, m_pc + 1);
        check_eq("wrap_addr", 32'(imem_addr), 32'h0);
        check_eq("wrap_pc", pc, 32'h400);
        check_eq("wrap_en", 32'(imem_en), 32'd1);
        check_eq("wrap_retired", retired, 32'd2);

        // Four-cycle stall during the second execute cycle
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, m_pc + 1);
        repeat (4) cycle(1'b0, 1'b1, m_pc + 1);
        repeat (10) cycle(1'b0, 1'b0, m_pc + 1);

        // Stall during FETCH re-issues the read
        do_reset();
        repeat (3) cycle(1'b0, 1'b1, m_pc + 1);
        repeat (6) cycle(1'b0, 1'b0, m_pc + 1);

        // Reset mid-EXEC discards the in-flight instruction
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, m_pc + 1);
        do_reset();
        cycle(1'b0, 1'b0, m_pc + 1);
        check_eq("rstmid_en", 32'(imem_en), 32'd1);
        check_eq("rstmid_pc", pc, 32'd0);
        check_eq("rstmid_retired", retired, 32'd0);

        // Randomized memory contents, stalls and branch targets
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < (1 << AW); i++) begin
                logic [W-1:0] w;
                w = $urandom;
                if ($urandom % 96 == 0) w[31:28] = 4'b0001;
                else if (is_halt_word(w)) w[28] = 1'b0;
                mem[i] = w;
            end
            do_reset();
            repeat (400) cycle(1'b0, ($urandom % 4) == 0, pick_npc());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
